lsu_byte_lane: RTL and testbench
================================

// Module: lsu_byte_lane
// PURPOSE
//  Load/store unit between the execute stage and four 8-bit dmem byte lanes (lane i = byte addr[1:0]==i).
//  - Converts byte/half/word requests into per-lane write enables and lane-aligned write data.
//  - Rebuilds sign/zero-extended load data from the synchronous-read lane outputs.
//  - Single outstanding request; valid/ready request side, registered response pulse.
// PARAMETERS
//  ADDR_W   32   byte-address width; mem_addr wraps modulo 2^ADDR_W
// PORTS
//  clk            in   1       clock, all state on posedge
//  rst            in   1       asynchronous reset, active-high
//  req_valid      in   1       request present
//  req_ready      out  1       request accepted when req_valid & req_ready
//  req_we         in   1       1=store, 0=load
//  req_addr       in   ADDR_W  byte address
//  req_size       in   2       00=byte 01=half 10=word 11=illegal
//  req_unsigned   in   1       loads: 1=zero-extend, 0=sign-extend
//  req_wdata      in   32      store data, LSB-justified
//  rsp_valid      out  1       one-cycle completion pulse
//  rsp_rdata      out  32      load result (0 for stores/errors)
//  rsp_err        out  1       request rejected, no memory write performed
//  mem_we         out  4       per-lane write enable
//  mem_addr       out  ADDR_W  word address to all lanes, bits[1:0]=00
//  mem_wdata      out  32      lane i data on [8i+7:8i]
//  mem_rdata      in   32      lane read data, valid the cycle after address (sync read)
// BEHAVIOUR
//  Reset: state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=0, mem_we=0 while rst high.
//  - Reset mid-operation aborts the request; a pending second store half is dropped.
//  - No response is produced for an aborted request.
//  States: IDLE, LD_WAIT, SECOND, LD_WAIT2.
//  - req_ready=1 only in IDLE and rst low.
//  IDLE: mem_addr/mem_we/mem_wdata driven combinationally from the request on the accept cycle T.
//  - off = req_addr[1:0], nbytes = 1/2/4.
//  - Lane enable = bytes off..off+nbytes-1 (mod 4); wdata byte k goes to lane (off+k)%4.
//  - Aligned store: mem_we issued at T -> IDLE; rsp_valid=1, rsp_err=0, rsp_rdata=0 at T+1.
//  - Aligned load: -> LD_WAIT; at T+1 capture mem_rdata and extract bytes off..off+nbytes-1.
//    Extract little-endian, extend per req_unsigned; rsp_valid at T+2.
//  - size 11: no mem_we, rsp_valid+rsp_err at T+1, rsp_rdata=0.
//  Misalignment: half with off=3, word with off!=0 (off+nbytes>4) is a crossing request.
//  - Without MISALIGNED_EN, any non-natural alignment is an error:
//    half with addr[0]=1, or word with off!=0.
//  - Error handling as for size 11.
//  Latched per request: size, unsigned, off, upper lanes/data.
//  - req_* may change after acceptance without effect.
//  mem_we never asserted outside the accept cycle or SECOND.
//  Back-to-back: a new request is accepted the cycle after rsp_valid at the earliest (IDLE re-entered).
// CONFIGURATION
//  MISALIGNED_EN defined: crossing requests split into two word accesses.
//  - Non-crossing unaligned requests complete in one access (e.g. half at off=1).
//  - T: word A=addr&~3, lanes off..3 -> SECOND.
//  - T+1: word A+4 (wraps), lanes 0..(off+nbytes-5), remaining bytes.
//  - Loads additionally capture first word at T+1, second word at T+2 (LD_WAIT2).
//  - Store rsp at T+2; load rsp at T+3, rsp_err=0.
//  MISALIGNED_EN undefined: SECOND/LD_WAIT2 unreachable, behaviour as above.
// TESTING
//  1. Store word 0xDEADBEEF @0x10 -> T: mem_addr=0x10, mem_we=1111,
//     mem_wdata=0xDEADBEEF; T+1 rsp_valid=1, err=0.
//  2. Lanes hold 0x80FF1234 @0x10; load byte signed @0x13 -> rsp_rdata=0xFFFFFF80 at T+2;
//     unsigned -> 0x00000080.
//  3. Store half 0xABCD @0x06 -> mem_we=1100, mem_wdata[31:16]=0xABCD, mem_addr=0x04;
//     load half signed @0x06 -> 0xFFFFABCD.
//  4. Without MISALIGNED_EN: store word @0x21 -> no mem_we, rsp_err=1 at T+1;
//     size 11 -> rsp_err=1.
//  5. With MISALIGNED_EN: store word 0x11223344 @0x0E ->
//     T: addr 0x0C, we=1100, data[31:16]=0x3344; T+1: addr 0x10, we=0011, data[15:0]=0x1122.
//     Load back at 0x0E -> 0x11223344 at T+3.
//  6. Assert rst during SECOND of case 5 -> mem_we=0 immediately, no rsp_valid,
//     req_ready=1 after release, word 0x10 unchanged.

Source files
------------

// File: rtl/lsu_byte_lane_if.sv
// Request/response bundle between the execute stage and the load/store unit.
// The master side issues valid/ready requests; the slave side returns a one-cycle response pulse.
interface lsu_byte_lane_if #(
  parameter int ADDR_W = 32
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/lsu_byte_lane.sv
// Load/store unit driving four 8-bit synchronous-read dmem byte lanes, single outstanding request.
// Optional MISALIGNED_EN: lane-crossing requests are split into two word accesses instead of erroring.
module lsu_byte_lane #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  lsu_byte_lane_if.slave    bus,
  output logic [3:0]        o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  input  logic [31:0]       i_mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LD_WAIT  = 2'd1,
    ST_SECOND   = 2'd2,
    ST_LD_WAIT2 = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nx;
  logic [1:0]        r_size;
  logic              r_uns;
  logic [1:0]        r_off;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr_a;
  logic [ADDR_W-1:0] r_addr_b;
  logic [3:0]        r_we2;
  logic [31:0]       r_wdata2;
  logic [31:0]       r_word0;
  logic              r_rsp_valid;
  logic              r_rsp_err;
  logic [31:0]       r_rsp_rdata;

  logic              w_ready;
  logic              w_accept;
  logic [1:0]        w_off;
  logic [3:0]        w_mask;
  logic [7:0]        w_lanes8;
  logic [63:0]       w_data64;
  logic              w_illegal;
  logic              w_err;
  logic              w_split;
  logic [ADDR_W-1:0] w_word_addr;
  logic [63:0]       w_rd64;
  logic [31:0]       w_rd_sh;
  logic [31:0]       w_load;
  logic              w_rsp_set;
  logic              w_rsp_err_nx;
  logic [31:0]       w_rsp_data_nx;

  function automatic logic [31:0] f_extend(input logic [31:0] d, input logic [1:0] size,
                                           input logic uns);
    logic [31:0] res;
    case (size)
      2'b00:   res = uns ? {24'h000000, d[7:0]}  : {{24{d[7]}}, d[7:0]};
      2'b01:   res = uns ? {16'h0000, d[15:0]}   : {{16{d[15]}}, d[15:0]};
      default: res = d;
    endcase
    return res;
  endfunction

  // Ready is withheld during the response cycle so a new request starts only after it.
  assign w_ready       = (r_state == ST_IDLE) & ~r_rsp_valid & ~rst;
  assign w_accept      = bus.req_valid & w_ready;
  assign w_off         = bus.req_addr[1:0];
  assign w_word_addr   = {bus.req_addr[ADDR_W-1:2], 2'b00};
  assign w_illegal     = (bus.req_size == 2'b11);
  assign w_lanes8      = {4'b0000, w_mask} << w_off;
  assign w_data64      = {32'h0000_0000, bus.req_wdata} << {w_off, 3'b000};
  assign w_rd64        = (r_state == ST_LD_WAIT2) ? {i_mem_rdata, r_word0}
                                                  : {32'h0000_0000, i_mem_rdata};
  assign w_rd_sh       = 32'(w_rd64 >> {r_off, 3'b000});
  assign w_load        = f_extend(w_rd_sh, r_size, r_uns);
  assign bus.req_ready = w_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.rsp_rdata = r_rsp_rdata;

  // Base lane mask for the access size before rotation to the byte offset.
  always_comb begin
    w_mask = 4'b1111;
    case (bus.req_size)
      2'b00:   w_mask = 4'b0001;
      2'b01:   w_mask = 4'b0011;
      default: w_mask = 4'b1111;
    endcase
  end

  // Upper nibble of the rotated mask marks bytes spilling into the next word.
  always_comb begin
`ifdef MISALIGNED_EN
    w_err   = w_illegal;
    w_split = (|w_lanes8[7:4]) & ~w_illegal;
`else
    w_err   = w_illegal | ((bus.req_size == 2'b01) & w_off[0]) |
              ((bus.req_size == 2'b10) & (w_off != 2'b00));
    w_split = 1'b0;
`endif
  end

  // Next-state, memory-port drive and response staging.
  always_comb begin
    w_state_nx    = r_state;
    o_mem_we      = 4'b0000;
    o_mem_addr    = r_addr_a;
    o_mem_wdata   = 32'h0000_0000;
    w_rsp_set     = 1'b0;
    w_rsp_err_nx  = 1'b0;
    w_rsp_data_nx = 32'h0000_0000;
    case (r_state)
      ST_IDLE: begin
        o_mem_addr  = w_word_addr;
        o_mem_wdata = w_data64[31:0];
        if (w_accept) begin
          if (w_err) begin
            w_rsp_set    = 1'b1;
            w_rsp_err_nx = 1'b1;
          end else if (w_split) begin
            o_mem_we   = bus.req_we ? w_lanes8[3:0] : 4'b0000;
            w_state_nx = ST_SECOND;
          end else if (bus.req_we) begin
            o_mem_we  = w_lanes8[3:0];
            w_rsp_set = 1'b1;
          end else begin
            w_state_nx = ST_LD_WAIT;
          end
        end else begin
          w_state_nx = ST_IDLE;
        end
      end
      ST_LD_WAIT: begin
        w_rsp_set     = 1'b1;
        w_rsp_data_nx = w_load;
        w_state_nx    = ST_IDLE;
      end
      ST_SECOND: begin
        o_mem_addr  = r_addr_b;
        o_mem_wdata = r_wdata2;
        if (r_we) begin
          o_mem_we   = r_we2;
          w_rsp_set  = 1'b1;
          w_state_nx = ST_IDLE;
        end else begin
          w_state_nx = ST_LD_WAIT2;
        end
      end
      ST_LD_WAIT2: begin
        w_rsp_set     = 1'b1;
        w_rsp_data_nx = w_load;
        w_state_nx    = ST_IDLE;
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Per-request context, so req_* may change freely after acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_size   <= 2'b00;
      r_uns    <= 1'b0;
      r_off    <= 2'b00;
      r_we     <= 1'b0;
      r_addr_a <= '0;
      r_addr_b <= '0;
      r_we2    <= 4'b0000;
      r_wdata2 <= 32'h0000_0000;
      r_word0  <= 32'h0000_0000;
    end else begin
      if (w_accept) begin
        r_size   <= bus.req_size;
        r_uns    <= bus.req_unsigned;
        r_off    <= w_off;
        r_we     <= bus.req_we;
        r_addr_a <= w_word_addr;
        r_addr_b <= w_word_addr + ADDR_W'(3'd4);
        r_we2    <= w_lanes8[7:4];
        r_wdata2 <= w_data64[63:32];
      end
      if (r_state == ST_SECOND) begin
        r_word0 <= i_mem_rdata;
      end
    end
  end

  // Registered response pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= 32'h0000_0000;
    end else begin
      r_rsp_valid <= w_rsp_set;
      r_rsp_err   <= w_rsp_err_nx;
      r_rsp_rdata <= w_rsp_data_nx;
    end
  end

endmodule

// File: tb/tb_lsu_byte_lane.sv
// Directed bench for lsu_byte_lane: vector table of single-access requests plus reset and split sequences.
module tb_lsu_byte_lane;
  localparam int AW = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_clr;
  logic [31:0] mem [0:63];
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  lsu_byte_lane_if #(.ADDR_W(AW)) bus ();

  lsu_byte_lane #(.ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .o_mem_we   (mem_we),
    .o_mem_addr (mem_addr),
    .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata)
  );

  // Four byte lanes, synchronous read of the old word.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem_rdata <= 32'h0;
    end else begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      mem_rdata <= mem[mem_addr[7:2]];
    end
  end

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
    logic [3:0]  exp_we;
    logic [31:0] exp_maddr;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wdata);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_addr     = addr;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_wdata    = wdata;
  endtask

  task automatic scramble();
    bus.req_valid    = 1'b0;
    bus.req_we       = ~bus.req_we;
    bus.req_addr     = 32'hFFFF_FFF3;
    bus.req_size     = 2'b11;
    bus.req_unsigned = ~bus.req_unsigned;
    bus.req_wdata    = 32'h5A5A_5A5A;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    bit          got;
    int          lat;
    int          exp_lat;
    logic [31:0] lmask;
    @(posedge clk); #1;
    drive(v.we, v.addr, v.size, v.uns, v.wdata);
    got = 1'b0;
    for (int c = 0; c < 8 && !got; c++) begin
      @(negedge clk);
      if (bus.req_ready) got = 1'b1;
    end
    if (!got) begin
      chk($sformatf("v%0d_ready_timeout", idx), 32'd0, 32'd1);
      bus.req_valid = 1'b0;
      return;
    end
    lmask = {{8{v.exp_we[3]}}, {8{v.exp_we[2]}}, {8{v.exp_we[1]}}, {8{v.exp_we[0]}}};
    chk($sformatf("v%0d_mem_we", idx), {28'h0, mem_we}, {28'h0, v.exp_we});
    if (!v.exp_err) begin
      chk($sformatf("v%0d_mem_addr", idx), mem_addr, v.exp_maddr);
      chk($sformatf("v%0d_mem_wdata", idx), mem_wdata & lmask, v.exp_wdata);
    end
    @(posedge clk); #1;
    scramble();
    exp_lat = (v.we || v.exp_err) ? 1 : 2;
    got = 1'b0;
    lat = 0;
    for (int c = 1; c <= 6 && !got; c++) begin
      @(negedge clk);
      chk($sformatf("v%0d_idle_we", idx), {28'h0, mem_we}, 32'h0);
      if (bus.rsp_valid) begin
        got = 1'b1;
        lat = c;
      end
    end
    chk($sformatf("v%0d_latency", idx), lat, exp_lat);
    if (got) begin
      chk($sformatf("v%0d_rdata", idx), bus.rsp_rdata, v.exp_rdata);
      chk($sformatf("v%0d_err", idx), {31'h0, bus.rsp_err}, {31'h0, v.exp_err});
      chk($sformatf("v%0d_ready_in_rsp", idx), {31'h0, bus.req_ready}, 32'h0);
    end
    @(negedge clk);
    chk($sformatf("v%0d_pulse_end", idx), {31'h0, bus.rsp_valid}, 32'h0);
    chk($sformatf("v%0d_ready_after", idx), {31'h0, bus.req_ready}, 32'h1);
  endtask

  initial begin
    // we addr size uns wdata | exp_we exp_maddr exp_wdata exp_rdata exp_err
    vecs.push_back('{1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, 4'b1111, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 32'h10, 2'b10, 1'b0, 32'h0,        4'b0000, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0});
    vecs.push_back('{1'b1, 32'h10, 2'b10, 1'b0, 32'h80FF1234, 4'b1111, 32'h10, 32'h80FF1234, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 32'h13, 2'b00, 1'b0, 32'h0,        4'b0000, 32'h10, 32'h0,        32'hFFFFFF80, 1'b0});
    vecs.push_back('{1'b0, 32'h13, 2'b00, 1'b1, 32'h0,        4'b0000, 32'h10, 32'h0,        32'h00000080, 1'b0});
    vecs.push_back('{1'b1, 32'h06, 2'b01, 1'b0, 32'h5555ABCD, 4'b1100, 32'h04, 32'hABCD0000, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 32'h06, 2'b01, 1'b0, 32'h0,        4'b0000, 32'h04, 32'h0,        32'hFFFFABCD, 1'b0});
    vecs.push_back('{1'b0, 32'h06, 2'b01, 1'b1, 32'h0,        4'b0000, 32'h04, 32'h0,        32'h0000ABCD, 1'b0});
    vecs.push_back('{1'b1, 32'h11, 2'b00, 1'b0, 32'hAAAAAA7E, 4'b0010, 32'h10, 32'h00007E00, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 32'h11, 2'b00, 1'b0, 32'h0,        4'b0000, 32'h10, 32'h0,        32'h0000007E, 1'b0});
    vecs.push_back('{1'b0, 32'h12, 2'b01, 1'b0, 32'h0,        4'b0000, 32'h10, 32'h0,        32'hFFFF80FF, 1'b0});
    vecs.push_back('{1'b0, 32'h10, 2'b00, 1'b0, 32'h0,        4'b0000, 32'h10, 32'h0,        32'h00000034, 1'b0});
    vecs.push_back('{1'b0, 32'h10, 2'b10, 1'b0, 32'h0,        4'b0000, 32'h10, 32'h0,        32'h80FF7E34, 1'b0});
    vecs.push_back('{1'b1, 32'h20, 2'b11, 1'b0, 32'h12345678, 4'b0000, 32'h20, 32'h0,        32'h0, 1'b1});
    vecs.push_back('{1'b0, 32'h10, 2'b11, 1'b0, 32'h0,        4'b0000, 32'h10, 32'h0,        32'h0, 1'b1});
`ifdef MISALIGNED_EN
    vecs.push_back('{1'b0, 32'h11, 2'b01, 1'b0, 32'h0,        4'b0000, 32'h10, 32'h0,        32'hFFFFFF7E, 1'b0});
`else
    vecs.push_back('{1'b1, 32'h21, 2'b10, 1'b0, 32'h12345678, 4'b0000, 32'h20, 32'h0,        32'h0, 1'b1});
    vecs.push_back('{1'b0, 32'h11, 2'b01, 1'b0, 32'h0,        4'b0000, 32'h10, 32'h0,        32'h0, 1'b1});
    vecs.push_back('{1'b0, 32'h12, 2'b10, 1'b0, 32'h0,        4'b0000, 32'h10, 32'h0,        32'h0, 1'b1});
    vecs.push_back('{1'b1, 32'h13, 2'b01, 1'b0, 32'h0000BEEF, 4'b0000, 32'h10, 32'h0,        32'h0, 1'b1});
`endif

    // Reset state, with a request presented that must not reach the memory.
    rst     = 1'b1;
    mem_clr = 1'b1;
    drive(1'b1, 32'h10, 2'b10, 1'b0, 32'hFFFFFFFF);
    repeat (3) @(negedge clk);
    chk("rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("rst_rsp_err",   {31'h0, bus.rsp_err}, 32'h0);
    chk("rst_req_ready", {31'h0, bus.req_ready}, 32'h0);
    chk("rst_mem_we",    {28'h0, mem_we}, 32'h0);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    rst           = 1'b0;
    mem_clr       = 1'b0;

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

    // Reset while a load waits for data: the response is dropped.
    @(posedge clk); #1;
    drive(1'b0, 32'h10, 2'b10, 1'b0, 32'h0);
    @(negedge clk);
    chk("rld_accept_ready", {31'h0, bus.req_ready}, 32'h1);
    @(posedge clk); #1;
    scramble();
    rst = 1'b1;
    @(negedge clk);
    chk("rld_mem_we", {28'h0, mem_we}, 32'h0);
    chk("rld_ready_in_rst", {31'h0, bus.req_ready}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("rld_no_rsp%0d", c), {31'h0, bus.rsp_valid}, 32'h0);
    end
    chk("rld_ready_after", {31'h0, bus.req_ready}, 32'h1);

`ifdef MISALIGNED_EN
    // Split store across words 0x0C and 0x10.
    @(posedge clk); #1;
    drive(1'b1, 32'h0E, 2'b10, 1'b0, 32'h11223344);
    @(negedge clk);
    chk("ms_t0_we",   {28'h0, mem_we}, 32'hC);
    chk("ms_t0_addr", mem_addr, 32'h0C);
    chk("ms_t0_data", {16'h0, mem_wdata[31:16]}, 32'h3344);
    @(posedge clk); #1;
    scramble();
    @(negedge clk);
    chk("ms_t1_we",   {28'h0, mem_we}, 32'h3);
    chk("ms_t1_addr", mem_addr, 32'h10);
    chk("ms_t1_data", {16'h0, mem_wdata[15:0]}, 32'h1122);
    chk("ms_t1_rsp",  {31'h0, bus.rsp_valid}, 32'h0);
    @(negedge clk);
    chk("ms_t2_rsp",  {31'h0, bus.rsp_valid}, 32'h1);
    chk("ms_t2_err",  {31'h0, bus.rsp_err}, 32'h0);
    // Split load back from 0x0E.
    @(negedge clk);
    @(posedge clk); #1;
    drive(1'b0, 32'h0E, 2'b10, 1'b0, 32'h0);
    @(negedge clk);
    chk("ml_t0_we",   {28'h0, mem_we}, 32'h0);
    chk("ml_t0_addr", mem_addr, 32'h0C);
    @(posedge clk); #1;
    scramble();
    @(negedge clk);
    chk("ml_t1_addr", mem_addr, 32'h10);
    chk("ml_t1_we",   {28'h0, mem_we}, 32'h0);
    @(negedge clk);
    chk("ml_t2_rsp",  {31'h0, bus.rsp_valid}, 32'h0);
    @(negedge clk);
    chk("ml_t3_rsp",  {31'h0, bus.rsp_valid}, 32'h1);
    chk("ml_t3_data", bus.rsp_rdata, 32'h11223344);
    chk("ml_t3_err",  {31'h0, bus.rsp_err}, 32'h0);
    // Reset during SECOND drops the second half.
    @(negedge clk);
    @(posedge clk); #1;
    drive(1'b1, 32'h0E, 2'b10, 1'b0, 32'h99887766);
    @(negedge clk);
    chk("mr_t0_we", {28'h0, mem_we}, 32'hC);
    @(posedge clk); #1;
    scramble();
    rst = 1'b1;
    @(negedge clk);
    chk("mr_we_in_rst", {28'h0, mem_we}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("mr_no_rsp%0d", c), {31'h0, bus.rsp_valid}, 32'h0);
    end
    chk("mr_ready_after", {31'h0, bus.req_ready}, 32'h1);
    run_vec('{1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 4'b0000, 32'h10, 32'h0, 32'h80FF1122, 1'b0}, 100);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
